// File: rtl/sa_tile_scheduler_if.sv
// Control/address bundle between the tile scheduler and its environment:
// start/config handshake, A/B/C SRAM address and enable lanes, PE array control.
interface sa_tile_scheduler_if #(
  parameter int ADDR_W = 11,
  parameter int DIM_W  = 8
);
  logic                start;
  logic [DIM_W-1:0]    cfg_m;
  logic [DIM_W-1:0]    cfg_n;
  logic [DIM_W-1:0]    cfg_k;
  logic [4*ADDR_W-1:0] addrA;
  logic [4*ADDR_W-1:0] addrB;
  logic [3:0]          a_valid;
  logic [3:0]          b_valid;
  logic                pe_clear;
  logic [1:0]          drain_sel;
  logic [4*ADDR_W-1:0] addrC;
  logic [3:0]          wenC;
  logic                busy;
  logic                finish;
  logic                cfg_err;

  modport master (
    output start, cfg_m, cfg_n, cfg_k,
    input  addrA, addrB, a_valid, b_valid, pe_clear, drain_sel,
    input  addrC, wenC, busy, finish, cfg_err
  );

  modport slave (
    input  start, cfg_m, cfg_n, cfg_k,
    output addrA, addrB, a_valid, b_valid, pe_clear, drain_sel,
    output addrC, wenC, busy, finish, cfg_err
  );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for a 4x4 systolic array: walks 4x4 output tiles of C = A*B,
// issuing skewed A/B reads, per-tile accumulator clears and row-by-row C drains.
module sa_tile_scheduler #(
  parameter int ADDR_W    = 11,
  parameter int DIM_W     = 8,
  parameter int FLUSH_CYC = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sa_tile_scheduler_if.slave   sched
);

  localparam int T_W    = DIM_W + 1;
  localparam int TILE_W = DIM_W - 2;
  localparam int FC_W   = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [T_W-1:0]      t_q;
  logic [FC_W-1:0]     fcnt_q;
  logic [TILE_W-1:0]   ti_q, tj_q;
  logic [TILE_W-1:0]   mt_q, nt_q;
  logic [DIM_W-1:0]    k_q;

  logic [4*ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q;
  logic [3:0]          a_valid_q, b_valid_q, wen_c_q;
  logic                pe_clear_q, busy_q, finish_q, cfg_err_q;
  logic [1:0]          drain_sel_q;

  logic [T_W-1:0]      t_d;
  logic [T_W-1:0]      t_last;
  logic [ADDR_W-1:0]   base_a, base_b;
  logic [TILE_W-1:0]   mt_last, nt_last;
  logic                cfg_ok;

  assign t_d     = t_q + 1'b1;
  assign t_last  = T_W'(k_q) + T_W'(2);
  assign base_a  = ADDR_W'(ti_q) * ADDR_W'(k_q);
  assign base_b  = ADDR_W'(tj_q) * ADDR_W'(k_q);
  assign mt_last = mt_q - TILE_W'(1);
  assign nt_last = nt_q - TILE_W'(1);

  assign cfg_ok = (sched.cfg_m != '0) && (sched.cfg_m[1:0] == 2'b00) &&
                  (sched.cfg_n != '0) && (sched.cfg_n[1:0] == 2'b00) &&
                  (sched.cfg_k != '0) && (sched.cfg_k[1:0] == 2'b00);

  // Lane r sees element k = t - r; outside [0, K) the address is clamped to the nearest edge.
  function automatic logic [ADDR_W-1:0] feed_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [T_W-1:0]    t,
                                                  input int                lane,
                                                  input logic [DIM_W-1:0]  k);
    int d;
    d = int'(t) - lane;
    if (d < 0) d = 0;
    else if (d >= int'(k)) d = int'(k) - 1;
    return base + ADDR_W'(d);
  endfunction

  function automatic logic lane_in_range(input logic [T_W-1:0]   t,
                                         input int               lane,
                                         input logic [DIM_W-1:0] k);
    int d;
    d = int'(t) - lane;
    return (d >= 0) && (d < int'(k));
  endfunction

  function automatic logic [ADDR_W-1:0] c_addr(input logic [TILE_W-1:0] ti,
                                               input logic [TILE_W-1:0] tj,
                                               input logic [1:0]        row,
                                               input logic [TILE_W-1:0] nt);
    return ((ADDR_W'(ti) << 2) + ADDR_W'(row)) * ADDR_W'(nt) + ADDR_W'(tj);
  endfunction

  // NOTE: every register in this block is assigned with <= so all updates take effect
  // together at the edge; a blocking = here would let later lines see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      fcnt_q      <= '0;
      ti_q        <= '0;
      tj_q        <= '0;
      mt_q        <= '0;
      nt_q        <= '0;
      k_q         <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      a_valid_q   <= '0;
      b_valid_q   <= '0;
      wen_c_q     <= '1;
      pe_clear_q  <= 1'b0;
      drain_sel_q <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      pe_clear_q <= 1'b0;
      finish_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sched.start) begin
            mt_q      <= sched.cfg_m[DIM_W-1:2];
            nt_q      <= sched.cfg_n[DIM_W-1:2];
            k_q       <= sched.cfg_k;
            ti_q      <= '0;
            tj_q      <= '0;
            t_q       <= '0;
            cfg_err_q <= !cfg_ok;
            if (cfg_ok) begin
              state_q    <= S_CLEAR;
              busy_q     <= 1'b1;
              pe_clear_q <= 1'b1;
            end else begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          state_q   <= S_FEED;
          t_q       <= '0;
          a_valid_q <= '0;
          b_valid_q <= '0;
          for (int r = 0; r < 4; r++) begin
            addr_a_q[r*ADDR_W +: ADDR_W] <= feed_addr(base_a, '0, r, k_q);
            addr_b_q[r*ADDR_W +: ADDR_W] <= feed_addr(base_b, '0, r, k_q);
          end
        end

        S_FEED: begin
          // Valids trail the address by one cycle to line up with the SRAM read data.
          for (int r = 0; r < 4; r++) begin
            a_valid_q[r] <= lane_in_range(t_q, r, k_q);
            b_valid_q[r] <= lane_in_range(t_q, r, k_q);
          end
          if (t_q == t_last) begin
            state_q <= S_FLUSH;
            fcnt_q  <= '0;
          end else begin
            t_q <= t_d;
            for (int r = 0; r < 4; r++) begin
              addr_a_q[r*ADDR_W +: ADDR_W] <= feed_addr(base_a, t_d, r, k_q);
              addr_b_q[r*ADDR_W +: ADDR_W] <= feed_addr(base_b, t_d, r, k_q);
            end
          end
        end

        S_FLUSH: begin
          a_valid_q <= '0;
          b_valid_q <= '0;
          if (fcnt_q == FC_W'(FLUSH_CYC - 1)) begin
            state_q     <= S_DRAIN;
            drain_sel_q <= 2'd0;
            wen_c_q     <= '0;
            addr_c_q    <= {4{c_addr(ti_q, tj_q, 2'd0, nt_q)}};
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_sel_q != 2'd3) begin
            drain_sel_q <= drain_sel_q + 2'd1;
            addr_c_q    <= {4{c_addr(ti_q, tj_q, drain_sel_q + 2'd1, nt_q)}};
          end else begin
            drain_sel_q <= 2'd0;
            wen_c_q     <= '1;
            if ((tj_q == nt_last) && (ti_q == mt_last)) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              // Row-major tile walk: column tile index advances first.
              if (tj_q == nt_last) begin
                tj_q <= '0;
                ti_q <= ti_q + 1'b1;
              end else begin
                tj_q <= tj_q + 1'b1;
              end
              state_q    <= S_CLEAR;
              pe_clear_q <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sched.addrA     = addr_a_q;
  assign sched.addrB     = addr_b_q;
  assign sched.addrC     = addr_c_q;
  assign sched.a_valid   = a_valid_q;
  assign sched.b_valid   = b_valid_q;
  assign sched.wenC      = wen_c_q;
  assign sched.pe_clear  = pe_clear_q;
  assign sched.drain_sel = drain_sel_q;
  assign sched.busy      = busy_q;
  assign sched.finish    = finish_q;
  assign sched.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: a cycle-level expectation queue is filled
// from an independent timing model at each start and drained one entry per clock.
module tb_sa_tile_scheduler;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int FL = 4;

  typedef struct {
    logic          pe_clear;
    logic [3:0]    valid;
    logic [3:0]    wen;
    logic          busy;
    logic          finish;
    logic          cfg_err;
    logic          chk_feed;
    logic [4*AW-1:0] addr_a;
    logic [4*AW-1:0] addr_b;
    logic          chk_drain;
    logic [1:0]    drain_sel;
    logic [4*AW-1:0] addr_c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  logic exp_cfg_err;
  exp_t sb[$];

  sa_tile_scheduler_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();

  sa_tile_scheduler #(.ADDR_W(AW), .DIM_W(DW), .FLUSH_CYC(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic exp_t idle_exp(input logic err);
    exp_t e;
    e.pe_clear  = 1'b0;
    e.valid     = 4'h0;
    e.wen       = 4'hF;
    e.busy      = 1'b0;
    e.finish    = 1'b0;
    e.cfg_err   = err;
    e.chk_feed  = 1'b0;
    e.addr_a    = '0;
    e.addr_b    = '0;
    e.chk_drain = 1'b0;
    e.drain_sel = 2'd0;
    e.addr_c    = '0;
    return e;
  endfunction

  function automatic int clamp_k(input int d, input int k);
    if (d < 0) return 0;
    if (d >= k) return k - 1;
    return d;
  endfunction

  // Expected behaviour for every cycle following an accepted start.
  task automatic push_run(input int m, input int n, input int k);
    exp_t e;
    int   mt, nt, len, ti, tj, row;
    logic [AW-1:0] ca;
    if (m == 0 || n == 0 || k == 0 || (m % 4) != 0 || (n % 4) != 0 || (k % 4) != 0) begin
      e = idle_exp(1'b1);
      e.finish = 1'b1;
      sb.push_back(e);
      exp_cfg_err = 1'b1;
      return;
    end
    exp_cfg_err = 1'b0;
    mt  = m / 4;
    nt  = n / 4;
    len = 1 + (k + 3) + FL + 4;
    for (int p = 0; p < mt * nt; p++) begin
      ti = p / nt;
      tj = p % nt;
      for (int o = 0; o < len; o++) begin
        e = idle_exp(1'b0);
        e.busy = 1'b1;
        if (o == 0) e.pe_clear = 1'b1;
        if (o >= 1 && o <= k + 3) begin
          e.chk_feed = 1'b1;
          for (int r = 0; r < 4; r++) begin
            e.addr_a[r*AW +: AW] = AW'(ti * k + clamp_k(o - 1 - r, k));
            e.addr_b[r*AW +: AW] = AW'(tj * k + clamp_k(o - 1 - r, k));
          end
        end
        if (o >= 2 && o <= k + 4)
          for (int r = 0; r < 4; r++) e.valid[r] = (o - 2 - r >= 0) && (o - 2 - r < k);
        if (o >= k + 4 + FL && o < k + 8 + FL) begin
          row         = o - (k + 4 + FL);
          ca          = AW'((4 * ti + row) * nt + tj);
          e.wen       = 4'h0;
          e.chk_drain = 1'b1;
          e.drain_sel = 2'(row);
          e.addr_c    = {4{ca}};
        end
        sb.push_back(e);
      end
    end
    e = idle_exp(1'b0);
    e.finish = 1'b1;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and compare the DUT against the head of the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0) e = sb.pop_front();
    else e = idle_exp(exp_cfg_err);
    check("pe_clear", 64'(bus.pe_clear), 64'(e.pe_clear));
    check("a_valid",  64'(bus.a_valid),  64'(e.valid));
    check("b_valid",  64'(bus.b_valid),  64'(e.valid));
    check("wenC",     64'(bus.wenC),     64'(e.wen));
    check("busy",     64'(bus.busy),     64'(e.busy));
    check("finish",   64'(bus.finish),   64'(e.finish));
    check("cfg_err",  64'(bus.cfg_err),  64'(e.cfg_err));
    if (e.chk_feed) begin
      check("addrA", 64'(bus.addrA), 64'(e.addr_a));
      check("addrB", 64'(bus.addrB), 64'(e.addr_b));
    end
    if (e.chk_drain) begin
      check("drain_sel", 64'(bus.drain_sel), 64'(e.drain_sel));
      check("addrC",     64'(bus.addrC),     64'(e.addr_c));
    end
  endtask

  task automatic start_run(input int m, input int n, input int k);
    bus.cfg_m = DW'(m);
    bus.cfg_n = DW'(n);
    bus.cfg_k = DW'(k);
    bus.start = 1'b1;
    push_run(m, n, k);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_run();
    while (sb.size() > 0) tick();
    tick();
  endtask

  task automatic reset_mid_op(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_wenC"},     64'(bus.wenC),     64'h0F);
    check({tag, "_a_valid"},  64'(bus.a_valid),  64'h0);
    check({tag, "_b_valid"},  64'(bus.b_valid),  64'h0);
    check({tag, "_busy"},     64'(bus.busy),     64'h0);
    check({tag, "_pe_clear"}, 64'(bus.pe_clear), 64'h0);
    check({tag, "_addrC"},    64'(bus.addrC),    64'h0);
    sb.delete();
    exp_cfg_err = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    exp_cfg_err = 1'b0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.cfg_m   = '0;
    bus.cfg_n   = '0;
    bus.cfg_k   = '0;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single 4x4x4 tile.
    start_run(4, 4, 4);
    finish_run();

    // Deeper inner dimension, single tile.
    start_run(4, 4, 8);
    finish_run();

    // 2x2 tiles.
    start_run(8, 8, 4);
    finish_run();

    // Invalid K, then a valid run starting the cycle after finish clears cfg_err.
    start_run(4, 4, 6);
    finish_run();
    start_run(4, 8, 4);
    finish_run();

    // Zero dimension is also rejected.
    start_run(0, 4, 4);
    finish_run();

    // A start during FEED with a different config must be ignored.
    start_run(8, 4, 4);
    repeat (3) tick();
    bus.cfg_m = DW'(4);
    bus.cfg_n = DW'(4);
    bus.cfg_k = DW'(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    finish_run();

    // Back-to-back identical runs.
    start_run(8, 4, 8);
    finish_run();
    start_run(8, 4, 8);
    finish_run();

    // Asynchronous reset in the middle of FEED.
    start_run(4, 4, 4);
    repeat (3) tick();
    reset_mid_op("rst_feed");

    // Asynchronous reset during DRAIN, when C writes are active.
    start_run(4, 4, 4);
    repeat (12) tick();
    check("pre_rst_drain_wenC", 64'(bus.wenC), 64'h0);
    reset_mid_op("rst_drain");

    // Clean run after reset.
    start_run(4, 4, 4);
    finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
